// File: rtl/img_buffer.sv
// img_buffer
//   Input stage of the BNN inference controller. Bytes arriving from the host
//   receive path over a valid/ready handshake are shifted into a packed image
//   register, first byte ending up in the most significant byte. Once all
//   NUM_BYTES bytes are held, img_buffer_full is raised and the image is frozen
//   until clear_buffer restarts the frame.
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   rx_data          received byte
//   rx_valid         rx_data is valid this cycle
//   rx_ready         buffer accepts a byte this cycle (combinational)
//   clear_buffer     synchronous discard of the image, priority over accept
//   img_out          packed image, byte 0 in the top byte
//   img_buffer_full  registered: whole image held, img_out stable
//   byte_count       bytes accepted in the current frame (0..NUM_BYTES)
module img_buffer #(
  parameter  int IMG_BITS  = 904,
  parameter  int BYTE_W    = 8,
  localparam int NUM_BYTES = IMG_BITS / BYTE_W,
  localparam int CNT_W     = $clog2(NUM_BYTES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  input  logic                clear_buffer,
  output logic [IMG_BITS-1:0] img_out,
  output logic                img_buffer_full,
  output logic [CNT_W-1:0]    byte_count
);

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    FILLING = 2'b01,
    FULL    = 2'b10
  } state_t;

  state_t state, state_next;

  logic accept;
  logic last_byte;
  logic state_ok;
  logic restart;

  assign state_ok  = (state == EMPTY) || (state == FILLING) || (state == FULL);
  assign rx_ready  = ((state == EMPTY) || (state == FILLING)) && !clear_buffer;
  assign accept    = rx_valid && rx_ready;
  assign last_byte = (byte_count == CNT_W'(NUM_BYTES - 1));
  // An illegal encoding is treated like a clear so the datapath restarts too.
  assign restart   = clear_buffer || !state_ok;

  always_comb begin
    state_next = state;
    if (clear_buffer) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) state_next = last_byte ? FULL : FILLING;
        FILLING: if (accept && last_byte) state_next = FULL;
        FULL:    state_next = FULL;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= EMPTY;
      img_out         <= '0;
      byte_count      <= '0;
      img_buffer_full <= 1'b0;
    end else begin
      state           <= state_next;
      // Registered from next-state so it rises together with the FULL state.
      img_buffer_full <= (state_next == FULL);
      if (restart) begin
        img_out    <= '0;
        byte_count <= '0;
      end else if (accept) begin
        img_out    <= {img_out[IMG_BITS-BYTE_W-1:0], rx_data};
        byte_count <= byte_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_img_buffer.sv
// Self-checking bench for img_buffer: directed scenarios plus a randomized
// section, all compared against a byte-queue reference model.
module tb_img_buffer;

  localparam int NB = 113;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         clear_buffer;
  logic [903:0] img_out;
  logic         img_buffer_full;
  logic [6:0]   byte_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: the bytes accepted so far this frame, and the full flag.
  logic [7:0] q[$];
  logic       m_full;

  img_buffer #(.IMG_BITS(904), .BYTE_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .clear_buffer    (clear_buffer),
    .img_out         (img_out),
    .img_buffer_full (img_buffer_full),
    .byte_count      (byte_count)
  );

  always #5 clk = ~clk;

  // Byte j of a k-byte partial frame sits at byte position k-1-j from the LSB.
  function automatic logic [903:0] model_img();
    logic [903:0] img;
    int k;
    img = '0;
    k = q.size();
    for (int j = 0; j < k; j++) img[8*(k-1-j) +: 8] = q[j];
    return img;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_img(input string tag, input logic [903:0] obs, input logic [903:0] exp);
    int first;
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      first = -1;
      for (int b = NB - 1; b >= 0; b--)
        if (first < 0 && obs[8*b +: 8] !== exp[8*b +: 8]) first = b;
      $error("FAIL %s: byte position %0d observed %02h expected %02h", tag, first,
             obs[8*first +: 8], exp[8*first +: 8]);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".byte_count"}, int'(byte_count), q.size());
    chk({tag, ".full"}, int'(img_buffer_full), int'(m_full));
    chk_img({tag, ".img_out"}, img_out, model_img());
  endtask

  // One clock cycle: drive at negedge, check rx_ready, update model at posedge.
  task automatic step(input logic v, input logic [7:0] d, input logic c, input string tag);
    @(negedge clk);
    rx_valid = v; rx_data = d; clear_buffer = c;
    #1;
    chk({tag, ".rx_ready"}, int'(rx_ready), int'(!m_full && !c));
    @(posedge clk);
    if (c) begin
      q.delete();
      m_full = 1'b0;
    end else if (v && !m_full) begin
      q.push_back(d);
      if (q.size() == NB) m_full = 1'b1;
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] bb;
    int first_acc, full_at, cyc;

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; clear_buffer = 1'b0;
    q.delete(); m_full = 1'b0;
    #12;
    check_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    #1 chk("reset.rx_ready", int'(rx_ready), 1);

    // Back-to-back frame, byte i = i; track cycles from first accept to full.
    first_acc = -1; full_at = -1; cyc = 0;
    for (int i = 0; i < NB; i++) begin
      bb = 8'(i);
      step(1'b1, bb, 1'b0, "seq");
      cyc++;
      if (first_acc < 0) first_acc = cyc;
      if (full_at < 0 && img_buffer_full) full_at = cyc;
    end
    chk("seq.latency", full_at - first_acc + 1, NB);
    chk("seq.top_byte", int'(img_out[903:896]), 0);
    chk("seq.low_byte", int'(img_out[7:0]), 8'h70);
    chk("seq.count", int'(byte_count), NB);
    #4 chk("seq.rx_ready_full", int'(rx_ready), 0);

    // Valid held while full: nothing consumed.
    for (int i = 0; i < 10; i++) step(1'b1, 8'hFF, 1'b0, "hold_full");

    // Clear, 50 bytes of A5, clear with a byte presented, then a random frame.
    step(1'b0, 8'h00, 1'b1, "clr0");
    for (int i = 0; i < 50; i++) step(1'b1, 8'hA5, 1'b0, "a5");
    step(1'b1, 8'h3C, 1'b1, "clr_mid");
    chk("clr_mid.count", int'(byte_count), 0);
    chk("clr_mid.full", int'(img_buffer_full), 0);
    for (int i = 0; i < NB; i++) step(1'b1, 8'($urandom), 1'b0, "refill");
    chk("refill.full", int'(img_buffer_full), 1);

    // Held clear keeps the buffer empty.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h11, 1'b1, "held_clr");

    // Valid toggling 1,0,1,0: full after 113 accepts.
    for (int i = 0; i < 2 * NB; i++) step(i[0] == 1'b0, 8'($urandom), 1'b0, "toggle");
    chk("toggle.full", int'(img_buffer_full), 1);

    // Async reset at byte 60, between edges.
    step(1'b0, 8'h00, 1'b1, "clr1");
    for (int i = 0; i < 60; i++) step(1'b1, 8'($urandom), 1'b0, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    q.delete(); m_full = 1'b0;
    check_outputs("async_rst");
    @(negedge clk) begin rst_n = 1'b1; rx_valid = 1'b0; end
    #1 chk("async_rst.rx_ready", int'(rx_ready), 1);
    chk("async_rst.count", int'(byte_count), 0);

    // Full frame, clear, then an all-ones frame.
    for (int i = 0; i < NB; i++) step(1'b1, 8'($urandom), 1'b0, "frame_a");
    step(1'b0, 8'h00, 1'b1, "clr2");
    for (int i = 0; i < NB; i++) step(1'b1, 8'hFF, 1'b0, "ones");
    chk("ones.full", int'(img_buffer_full), 1);
    chk_img("ones.all", img_out, {904{1'b1}});

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 99) < 2), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/img_buffer.md
Name: img_buffer

Overview:
- Upstream stage of the BNN inference controller.
- Accepts the input image as a stream of bytes over a valid/ready handshake from the host receive path.
- Packs the bytes into a 904-bit image register and raises img_buffer_full once the whole image is held.
- Holds the image stable until the system controller clears it for the next frame.

Parameters:
- IMG_BITS, 904, width of the packed image; must be a multiple of BYTE_W.
- BYTE_W, 8, width of one received byte.
- NUM_BYTES, IMG_BITS/BYTE_W (113), bytes per image; derived, not overridden.
- CNT_W, $clog2(NUM_BYTES+1) (7), width of the byte counter; derived.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- rx_data, input, 8, received byte.
- rx_valid, input, 1, rx_data is valid this cycle.
- rx_ready, output, 1, the buffer accepts a byte this cycle.
- clear_buffer, input, 1, synchronous request to discard the image and restart filling.
- img_out, output, 904, packed image; the first byte received lands in [903:896].
- img_buffer_full, output, 1, all NUM_BYTES bytes are held and img_out is stable.
- byte_count, output, 7, number of bytes accepted in the current frame (0..113).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = EMPTY, img_out = 0, byte_count = 0, img_buffer_full = 0.
  - rx_ready = 1 after reset deasserts.
- Accept condition: rx_valid && rx_ready && !clear_buffer, sampled on the rising edge.
- On accept:
  - img_out <= {img_out[IMG_BITS-BYTE_W-1:0], rx_data}, a left shift by one byte.
  - byte_count increments by 1.
  - After NUM_BYTES accepts, byte 0 sits in [903:896] and byte 112 in [7:0].
  - Bits [3:0] of byte 112 are padding; downstream drops them.
- States:
  - EMPTY (byte_count = 0). Goes to FILLING on accept.
  - FILLING (0 < byte_count < 113). Stays in FILLING on accept while byte_count+1 < NUM_BYTES. Goes to FULL on the accept that makes byte_count = NUM_BYTES.
  - FULL (byte_count = 113). Goes to EMPTY only on clear_buffer.
- rx_ready is combinational: 1 in EMPTY and FILLING, 0 in FULL, and 0 in any cycle where clear_buffer = 1.
- img_buffer_full is registered.
  - It rises in the same cycle the state enters FULL, i.e. the cycle after the 113th accepting edge.
  - It stays 1 until clear.
- Latency: with back-to-back valid bytes, img_buffer_full is high 113 cycles after the first accepting edge.
- rx_valid in FULL: no handshake, the byte is not consumed, and img_out is unchanged. The upstream holds its byte.
- clear_buffer:
  - Honoured in any state, including mid-fill.
  - On the next edge: state = EMPTY, byte_count = 0, img_out = 0, img_buffer_full = 0.
  - A byte presented in the same cycle is not accepted.
  - Clear has priority over accept.
- Held clear_buffer keeps the block in EMPTY. Acceptance resumes the first cycle clear_buffer is 0.
- rx_valid idle cycles mid-frame: the count and partial image are retained indefinitely. There is no timeout.
- Asynchronous reset mid-frame discards the partial image immediately.
- byte_count never exceeds NUM_BYTES and never wraps.
- An illegal state encoding recovers to EMPTY with byte_count = 0.

Test Plan:
- Reset, then stream 113 bytes back-to-back with byte i = i[7:0] -> img_buffer_full rises 113 cycles after the first accept; img_out[903:896] = 0x00; img_out[7:0] = 0x70; byte_count = 113; rx_ready = 0.
- After full, hold rx_valid = 1 with rx_data = 0xFF for 10 cycles -> img_out and byte_count unchanged; img_buffer_full stays 1.
- Send 50 bytes of 0xA5, assert clear_buffer for 1 cycle with rx_valid = 1 -> that byte is dropped; next cycle byte_count = 0, img_out = 0, img_buffer_full = 0; a following 113-byte frame fills normally.
- Stream a frame with rx_valid toggling 1,0,1,0 -> full after 113 accepts (~226 cycles); image contents match the byte order.
- Assert rst_n = 0 asynchronously at byte 60 -> all outputs zero with no clock edge; after release, byte_count = 0 and rx_ready = 1.
- Full frame followed by clear_buffer and an immediate new frame of all 0xFF -> img_out = all ones; img_buffer_full re-asserts after 113 accepts.
